// File: rtl/bus_arbiter_if.sv
// Request/select bundle between the two bus masters and the arbiter.
// The master modport is the requestor side, the slave modport is the arbiter side.
interface bus_arbiter_if;
  logic       m1_req;
  logic [1:0] m1_slave_id;
  logic       m2_req;
  logic [1:0] m2_slave_id;
  logic [1:0] bus_grant;
  logic [1:0] slave_sel;
  logic       m1_granted;
  logic       m2_granted;
  logic       timeout;
  logic       id_err;

  modport master (
    output m1_req, m1_slave_id, m2_req, m2_slave_id,
    input  bus_grant, slave_sel, m1_granted, m2_granted, timeout, id_err
  );

  modport slave (
    input  m1_req, m1_slave_id, m2_req, m2_slave_id,
    output bus_grant, slave_sel, m1_granted, m2_granted, timeout, id_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with a per-grant watchdog and a one-cycle
// turnaround between owners. All bus-facing outputs come straight from flops.
//
// state | meaning
// IDLE  | bus free; arbitrate eligible requests every cycle
// GRANT | bus owned; select pair frozen, watchdog counting
// TURN  | single dead cycle after a release or revoke
module bus_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input logic         clk,
  input logic         rst,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state;
  logic [1:0]       grant_q;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] cnt;
  logic             last_m2;
  logic             lock_m1;
  logic             lock_m2;
  logic             timeout_q;
  logic             id_err_q;

  logic       elig_m1;
  logic       elig_m2;
  logic       pick_m2;
  logic [1:0] win_id;
  logic       owner_req;

  always_comb begin
    elig_m1   = bus.m1_req & ~lock_m1;
    elig_m2   = bus.m2_req & ~lock_m2;
    // On a tie the master that did not own the bus last wins.
    pick_m2   = elig_m2 & (~elig_m1 | ~last_m2);
    win_id    = pick_m2 ? bus.m2_slave_id : bus.m1_slave_id;
    owner_req = (grant_q == 2'd2) ? bus.m2_req : bus.m1_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant_q   <= 2'd0;
      sel_q     <= 2'd0;
      cnt       <= '0;
      last_m2   <= 1'b1;
      lock_m1   <= 1'b0;
      lock_m2   <= 1'b0;
      timeout_q <= 1'b0;
      id_err_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      id_err_q  <= 1'b0;
      if (!bus.m1_req) lock_m1 <= 1'b0;
      if (!bus.m2_req) lock_m2 <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (elig_m1 || elig_m2) begin
            if (win_id == 2'd0) begin
              id_err_q <= 1'b1;
            end else begin
              state   <= GRANT;
              grant_q <= pick_m2 ? 2'd2 : 2'd1;
              sel_q   <= win_id;
            end
          end
        end

        GRANT: begin
          if (!owner_req) begin
            state   <= TURN;
            grant_q <= 2'd0;
            sel_q   <= 2'd0;
            cnt     <= '0;
            last_m2 <= (grant_q == 2'd2);
          end else if (TIMEOUT != 0 && cnt == TERM_CNT) begin
            state     <= TURN;
            grant_q   <= 2'd0;
            sel_q     <= 2'd0;
            cnt       <= '0;
            timeout_q <= 1'b1;
            last_m2   <= (grant_q == 2'd2);
            if (grant_q == 2'd2) lock_m2 <= 1'b1;
            else                 lock_m1 <= 1'b1;
          end else if (TIMEOUT == 0) begin
            cnt <= '0;
          end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end

        TURN: begin
          state   <= IDLE;
          grant_q <= 2'd0;
          sel_q   <= 2'd0;
          cnt     <= '0;
        end

        default: begin
          state   <= IDLE;
          grant_q <= 2'd0;
          sel_q   <= 2'd0;
          cnt     <= '0;
        end
      endcase
    end
  end

  assign bus.bus_grant  = grant_q;
  assign bus.slave_sel  = sel_q;
  assign bus.m1_granted = (grant_q == 2'd1);
  assign bus.m2_granted = (grant_q == 2'd2);
  assign bus.timeout    = timeout_q;
  assign bus.id_err     = id_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a per-cycle vector table for the basic
// arbitration cases, then hand-written watchdog and async-reset sequences.
module tb_bus_arbiter;

  logic clk;
  logic rst;

  bus_arbiter_if bif ();

  bus_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       r1;
    logic [1:0] id1;
    logic       r2;
    logic [1:0] id2;
    logic [1:0] g;
    logic [1:0] s;
    logic       to;
    logic       ie;
  } vec_t;

  localparam int NVEC = 33;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r1, input logic [1:0] id1,
                       input logic r2, input logic [1:0] id2);
    bif.m1_req      = r1;
    bif.m1_slave_id = id1;
    bif.m2_req      = r2;
    bif.m2_slave_id = id2;
  endtask

  task automatic chk_out(input string tag, input int g, input int s,
                         input int to, input int ie);
    chk({tag, ".grant"},   int'(bif.bus_grant), g);
    chk({tag, ".sel"},     int'(bif.slave_sel), s);
    chk({tag, ".timeout"}, int'(bif.timeout), to);
    chk({tag, ".id_err"},  int'(bif.id_err), ie);
    chk({tag, ".m1g"},     int'(bif.m1_granted), (g == 1) ? 1 : 0);
    chk({tag, ".m2g"},     int'(bif.m2_granted), (g == 2) ? 1 : 0);
  endtask

  function automatic vec_t v(input logic r1, input logic [1:0] id1,
                             input logic r2, input logic [1:0] id2,
                             input logic [1:0] g, input logic [1:0] s,
                             input logic to, input logic ie);
    vec_t x;
    x = '{r1: r1, id1: id1, r2: r2, id2: id2, g: g, s: s, to: to, ie: ie};
    return x;
  endfunction

  initial begin
    // single M1 request, release, turnaround
    vecs[0]  = v(1, 2, 0, 0, 1, 2, 0, 0);
    vecs[1]  = v(1, 2, 0, 0, 1, 2, 0, 0);
    vecs[2]  = v(0, 2, 0, 0, 0, 0, 0, 0);
    vecs[3]  = v(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = v(0, 0, 0, 0, 0, 0, 0, 0);
    // slave_id changes mid-grant are ignored
    vecs[5]  = v(1, 1, 0, 0, 1, 1, 0, 0);
    vecs[6]  = v(1, 3, 0, 0, 1, 1, 0, 0);
    vecs[7]  = v(1, 3, 0, 0, 1, 1, 0, 0);
    vecs[8]  = v(0, 3, 0, 0, 0, 0, 0, 0);
    vecs[9]  = v(0, 0, 0, 0, 0, 0, 0, 0);
    // zero slave_id: id_err every IDLE cycle, then grant once fixed
    vecs[10] = v(0, 0, 1, 0, 0, 0, 0, 1);
    vecs[11] = v(0, 0, 1, 0, 0, 0, 0, 1);
    vecs[12] = v(0, 0, 1, 1, 2, 1, 0, 0);
    vecs[13] = v(0, 0, 0, 1, 0, 0, 0, 0);
    vecs[14] = v(0, 0, 0, 0, 0, 0, 0, 0);
    // both masters requesting: alternation M1, M2, M1, M2
    vecs[15] = v(1, 1, 1, 3, 1, 1, 0, 0);
    vecs[16] = v(1, 1, 1, 3, 1, 1, 0, 0);
    vecs[17] = v(1, 1, 1, 3, 1, 1, 0, 0);
    vecs[18] = v(1, 1, 1, 3, 1, 1, 0, 0);
    vecs[19] = v(0, 1, 1, 3, 0, 0, 0, 0);
    vecs[20] = v(1, 1, 1, 3, 0, 0, 0, 0);
    vecs[21] = v(1, 1, 1, 3, 2, 3, 0, 0);
    vecs[22] = v(1, 1, 1, 3, 2, 3, 0, 0);
    vecs[23] = v(1, 1, 1, 3, 2, 3, 0, 0);
    vecs[24] = v(1, 1, 1, 3, 2, 3, 0, 0);
    vecs[25] = v(1, 1, 0, 3, 0, 0, 0, 0);
    vecs[26] = v(1, 1, 1, 3, 0, 0, 0, 0);
    vecs[27] = v(1, 1, 1, 3, 1, 1, 0, 0);
    vecs[28] = v(0, 1, 1, 3, 0, 0, 0, 0);
    vecs[29] = v(0, 1, 1, 3, 0, 0, 0, 0);
    vecs[30] = v(0, 1, 1, 3, 2, 3, 0, 0);
    vecs[31] = v(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[32] = v(0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b0;
    drive(0, 0, 0, 0);
    #12;
    chk_out("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].r1, vecs[i].id1, vecs[i].r2, vecs[i].id2);
      tick();
      chk_out($sformatf("vec%0d", i), int'(vecs[i].g), int'(vecs[i].s),
              int'(vecs[i].to), int'(vecs[i].ie));
    end

    // Watchdog: last owner was M2, so M1 wins the tie and holds for 8 cycles.
    drive(1, 2, 1, 3);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_out($sformatf("wd_hold%0d", k), 1, 2, 0, 0);
    end
    tick();
    chk_out("wd_revoke", 0, 0, 1, 0);
    tick();
    chk_out("wd_turn", 0, 0, 0, 0);
    tick();
    chk_out("wd_m2_wins", 2, 3, 0, 0);
    tick();
    chk_out("wd_m2_hold", 2, 3, 0, 0);
    drive(1, 2, 0, 3);
    tick();
    chk_out("wd_m2_rel", 0, 0, 0, 0);
    tick();
    chk_out("wd_idle", 0, 0, 0, 0);
    tick();
    chk_out("wd_m1_locked", 0, 0, 0, 0);
    drive(0, 2, 0, 3);
    tick();
    chk_out("wd_m1_low", 0, 0, 0, 0);
    drive(1, 2, 0, 3);
    tick();
    chk_out("wd_m1_regrant", 1, 2, 0, 0);

    // Release M1 so last owner becomes M1, then give M2 the bus.
    drive(0, 2, 0, 3);
    tick();
    chk_out("pre_rst_turn", 0, 0, 0, 0);
    tick();
    drive(0, 2, 1, 3);
    tick();
    chk_out("pre_rst_m2", 2, 3, 0, 0);

    // Async reset between edges drops the grant immediately.
    #2;
    rst = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    drive(1, 1, 1, 3);
    tick();
    chk_out("rst_held", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk_out("post_rst_m1_tie", 1, 1, 0, 0);

    drive(0, 0, 0, 0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
